// File: rtl/cmp_stream.sv
// Two-stage streaming comparator. Stage 1 registers the subtract flags and
// the mode. Stage 2 registers the decoded result. Valid/ready back-pressure
// runs through both stages. A saturating counter tracks delivered true results.
module cmp_stream #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     I0,
    input  logic [WIDTH-1:0]     I1,
    input  logic [2:0]           MODE,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 O,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    typedef enum logic [2:0] {
        M_UGT = 3'd0, M_UGE = 3'd1, M_ULT = 3'd2, M_ULE = 3'd3,
        M_SGT = 3'd4, M_SGE = 3'd5, M_EQ  = 3'd6, M_NE  = 3'd7
    } mode_e;

    typedef struct packed {
        logic  c;
        logic  z;
        logic  n;
        logic  v;
        mode_e mode;
    } flags_t;

    // vld_pipe[1]: stage-1 holds a beat; vld_pipe[2]: result beat on O
    logic [2:1]     vld_pipe;
    flags_t         s1, s1_d;
    logic [WIDTH:0] diff;
    logic           ld2;
    logic           o_d;

    // Stage 2 takes a new beat whenever its current one is gone or leaving
    assign ld2       = ~vld_pipe[2] | out_ready;
    assign in_ready  = ~vld_pipe[1] | ld2;
    assign out_valid = vld_pipe[2];

    // I0 - I1 as I0 + ~I1 + 1; the carry out is the unsigned "no borrow"
    always_comb begin
        diff      = {1'b0, I0} + {1'b0, ~I1} + (WIDTH+1)'(1);
        s1_d.c    = diff[WIDTH];
        s1_d.z    = (I0 == I1);
        s1_d.n    = diff[WIDTH-1];
        s1_d.v    = (I0[WIDTH-1] ^ I1[WIDTH-1]) & (diff[WIDTH-1] ^ I0[WIDTH-1]);
        s1_d.mode = mode_e'(MODE);
    end

    // Predicate decode from the stage-1 flags
    always_comb begin
        o_d = 1'b0;
        case (s1.mode)
            M_UGT:   o_d = s1.c & ~s1.z;
            M_UGE:   o_d = s1.c;
            M_ULT:   o_d = ~s1.c;
            M_ULE:   o_d = ~s1.c | s1.z;
            M_SGT:   o_d = ~(s1.n ^ s1.v) & ~s1.z;
            M_SGE:   o_d = ~(s1.n ^ s1.v);
            M_EQ:    o_d = s1.z;
            M_NE:    o_d = ~s1.z;
            default: o_d = 1'b0;
        endcase
    end

    // Valid bits: reset discards anything in flight
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            vld_pipe <= '0;
        end else begin
            if (in_ready) vld_pipe[1] <= in_valid;
            if (ld2)      vld_pipe[2] <= vld_pipe[1];
        end
    end

    // Stage-1 payload only moves on an accepted beat; bubbles leave it alone
    always_ff @(posedge CLK) begin
        if (in_valid & in_ready) s1 <= s1_d;
    end

    // Result register holds through stalls and bubbles
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN)          O <= 1'b0;
        else if (ld2 & vld_pipe[1]) O <= o_d;
    end

    // Count delivered true results. Saturate at all-ones. Clear wins.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (out_valid & out_ready & O & ~&cnt)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: doc/cmp_stream.md
CMP_STREAM -- requirements
Module: cmp_stream

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 Parameter CNT_WIDTH, default 16, width of the true-result counter; legal range 2..32.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 ASYNCRESETN  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the operand beat this cycle.
REQ-007 I0  input  WIDTH  left operand.
REQ-008 I1  input  WIDTH  right operand.
REQ-009 MODE  input  3  compare mode, sampled with the operands.
REQ-010 out_valid  output  1  result beat available.
REQ-011 out_ready  input  1  downstream accepts the result beat.
REQ-012 O  output  1  compare result, qualified by out_valid.
REQ-013 clr  input  1  synchronous clear of cnt.
REQ-014 cnt  output  CNT_WIDTH  number of delivered results with O=1, saturating.

Function
REQ-015 MODE encoding SHALL be: 0 UGT, 1 UGE, 2 ULT, 3 ULE, 4 SGT, 5 SGE, 6 EQ, 7 NE; each predicate reads as I0 op I1; S modes use two's complement.
REQ-016 Stage 1 SHALL register D = I0 + ~I1 + 1 over WIDTH+1 bits, giving carry C (1 iff I0 >= I1 unsigned), Z (I0 == I1), N (D[WIDTH-1]) and V (signed overflow), plus MODE.
REQ-017 Stage 2 SHALL register O decoded from the stage-1 flags: UGT = C & ~Z; UGE = C; ULT = ~C; ULE = ~C | Z; SGT = ~(N^V) & ~Z; SGE = ~(N^V); EQ = Z; NE = ~Z.
REQ-018 An input transfer SHALL occur when in_valid & in_ready; an output transfer when out_valid & out_ready.
REQ-019 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no back-pressure; throughput SHALL be 1 beat per cycle.
REQ-020 Stage 2 SHALL load when out_valid is 0 or out_ready is 1; otherwise O and out_valid SHALL hold.
REQ-021 Stage 1 SHALL advance when stage 2 loads; in_ready = ~s1_valid | stage-2-load (combinational, no dependency on in_valid).
REQ-022 Beats SHALL never be dropped, duplicated or reordered under any out_ready pattern; O SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 cnt SHALL increment by 1 on each output transfer with O=1 and saturate at 2^CNT_WIDTH-1.
REQ-024 clr=1 SHALL set cnt to 0 on the next edge, taking priority over a simultaneous increment.
REQ-025 in_valid=0 cycles SHALL insert bubbles; no stage state SHALL change for a stage holding no valid beat except its valid bit.

Reset
REQ-026 ASYNCRESETN=0 SHALL immediately clear s1_valid, out_valid, O and cnt to 0, regardless of CLK.
REQ-027 Beats in flight at reset assertion SHALL be discarded; no out_valid SHALL appear for them after release.
REQ-028 in_ready SHALL be 1 while reset is asserted and in the first cycle after release.

Verification
REQ-029 WIDTH=2, out_ready=1; stream all 16 operand pairs under each of the 8 modes -> O matches REQ-017 truth for every pair, 2-cycle latency, e.g. UGT I0=2,I1=1 -> O=1 and SGT I0=2,I1=1 -> O=0.
REQ-030 WIDTH=8, SGE I0=0x80, I1=0x7F -> O=0; UGE same operands -> O=1; EQ I0=I1=0xA5 -> O=1.
REQ-031 Back-pressure: 5 beats offered back-to-back, out_ready=0 for 4 cycles then 1 -> in_ready drops after 2 beats accepted, all 5 results delivered in order with O held stable while stalled.
REQ-032 CNT_WIDTH=2: deliver 5 results with O=1 -> cnt 1,2,3,3,3; clr asserted in the same cycle as an O=1 transfer -> cnt=0.
REQ-033 Assert ASYNCRESETN=0 mid-cycle with 2 beats in flight -> out_valid, O and cnt go to 0 before the next CLK edge; after release no stale beat emerges and in_ready=1.
